// File: rtl/nzcv_cond_unit.sv
// nzcv_cond_unit: architectural NZCV flag register plus ARM condition-code
// evaluator. The unit captures ALU flags on S-bit retirement and accepts MSR
// writes. It tracks S-bit instructions still in flight with a saturating
// counter, and answers condition-evaluation requests through a req/ack
// handshake that stalls until the flags it depends on have landed.
//
// Handshake (cond_req / cond_ack):
//   The requester raises cond_req and holds it, with cond stable, until it
//   sees cond_ack. cond_ack is a single-cycle pulse; cond_pass is valid in
//   that cycle and keeps its value until the next evaluation completes.
//   While cond_ack is high, cond_req is ignored. If cond_req drops while the
//   unit is stalled, the request is abandoned and no ack is produced.
//   A reset abandons any request in flight; the requester must re-issue it.
module nzcv_cond_unit #(
    parameter bit BYPASS   = 1'b1,  // forward same-cycle flag_we data into evaluation
    parameter int PEND_MAX = 3,     // saturation value of the pending-S counter
    parameter int PEND_W   = 2      // pending counter width
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_issue,
    input  logic              flag_we,
    input  logic [4:1]        nzcv_in,
    input  logic              msr_we,
    input  logic [4:1]        msr_nzcv,
    input  logic              cond_req,
    input  logic [4:1]        cond,
    output logic              cond_ack,
    output logic              cond_pass,
    output logic              stall,
    output logic [4:1]        nzcv_q,
    output logic              cf,
    output logic              vf,
    output logic              pend_err,
    output logic [1:0]        state_dbg,
    output logic [PEND_W-1:0] pend_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [PEND_W-1:0] PEND_SAT  = PEND_W'(PEND_MAX);
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    state_t            state;
    state_t            state_nx;
    logic [4:1]        flags_q;
    logic [PEND_W-1:0] pend_q;
    logic              pend_err_q;
    logic              pass_q;

    logic [4:1]        eff_flags;
    logic              ready;
    logic              cond_eval;
    logic              take_result;

    // ARM condition table evaluated against a flag vector [4]=N [3]=Z [2]=C [1]=V.
    function automatic logic eval_cond(input logic [3:0] code, input logic [4:1] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic r;
        n = f[4];
        z = f[3];
        c = f[2];
        v = f[1];
        r = 1'b0;
        case (code)
            4'b0000: r = z;                    // EQ
            4'b0001: r = !z;                   // NE
            4'b0010: r = c;                    // CS
            4'b0011: r = !c;                   // CC
            4'b0100: r = n;                    // MI
            4'b0101: r = !n;                   // PL
            4'b0110: r = v;                    // VS
            4'b0111: r = !v;                   // VC
            4'b1000: r = c && !z;              // HI
            4'b1001: r = !c || z;              // LS
            4'b1010: r = (n == v);             // GE
            4'b1011: r = (n != v);             // LT
            4'b1100: r = !z && (n == v);       // GT
            4'b1101: r = z || (n != v);        // LE
            4'b1110: r = 1'b1;                 // AL
            default: r = 1'b0;                 // NV
        endcase
        return r;
    endfunction

    // Effective flags, readiness and the condition result for this cycle.
    // A request is ready when no S-bit instruction is outstanding and none is
    // entering execute now. With forwarding enabled, the last outstanding one
    // retiring this very cycle also counts, because its flags are visible on
    // nzcv_in.
    always_comb begin
        eff_flags = flags_q;
        ready     = 1'b0;
        if (BYPASS && flag_we) begin
            eff_flags = nzcv_in;
        end
        if (!s_issue) begin
            if (pend_q == PEND_ZERO) begin
                ready = 1'b1;
            end else if (BYPASS && flag_we && (pend_q == PEND_ONE)) begin
                ready = 1'b1;
            end
        end
        cond_eval = eval_cond(cond, eff_flags);
    end

    // Architectural flags: a retiring S-bit result takes priority over MSR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (flag_we) begin
            flags_q <= nzcv_in;
        end else if (msr_we) begin
            flags_q <= msr_nzcv;
        end
    end

    // Pending-S counter: saturates at PEND_MAX and flags the overflow
    // stickily. It never underflows. An issue and a retire in the same cycle
    // cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_err_q <= 1'b0;
        end else begin
            case ({s_issue, flag_we})
                2'b10: begin
                    if (pend_q == PEND_SAT) begin
                        pend_err_q <= 1'b1;
                    end else begin
                        pend_q <= pend_q + PEND_ONE;
                    end
                end
                2'b01: begin
                    if (pend_q != PEND_ZERO) begin
                        pend_q <= pend_q - PEND_ONE;
                    end
                end
                default: begin
                    pend_q <= pend_q;
                end
            endcase
        end
    end

    // Evaluation FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Evaluation FSM next state: IDLE waits for a request, STALL waits for
    // the flags, and DONE is the single ack cycle.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (cond_req) begin
                    state_nx = ready ? ST_DONE : ST_STALL;
                end
            end
            ST_STALL: begin
                if (!cond_req) begin
                    state_nx = ST_IDLE;
                end else if (ready) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign take_result = (state != ST_DONE) && (state_nx == ST_DONE);

    // Result register: loads on entry to DONE and holds until the next evaluation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 1'b0;
        end else if (take_result) begin
            pass_q <= cond_eval;
        end
    end

    assign cond_ack  = (state == ST_DONE);
    assign cond_pass = pass_q;
    assign stall     = (state == ST_STALL);
    assign nzcv_q    = flags_q;
    assign cf        = flags_q[2];
    assign vf        = flags_q[1];
    assign pend_err  = pend_err_q;
    assign state_dbg = state;
    assign pend_dbg  = pend_q;

endmodule

// File: tb/tb_nzcv_cond_unit.sv
// Directed bench for nzcv_cond_unit. Two instances share all inputs except
// cond_req: u_dut forwards same-cycle flags and u_dut_b0 does not. This lets
// the stall-resolution timing of both variants be compared in one run.
module tb_nzcv_cond_unit;

  logic       clk;
  logic       rst_n;
  logic       s_issue;
  logic       flag_we;
  logic [4:1] nzcv_in;
  logic       msr_we;
  logic [4:1] msr_nzcv;
  logic       req1;
  logic       req0;
  logic [4:1] cond;

  logic       ack1, pass1, stall1, cf1, vf1, perr1;
  logic [4:1] nzcv1;
  logic [1:0] st1;
  logic [1:0] pend1;

  logic       ack0, pass0, stall0, cf0, vf0, perr0;
  logic [4:1] nzcv0;
  logic [1:0] st0;
  logic [1:0] pend0;

  int checks;
  int errors;

  nzcv_cond_unit #(.BYPASS(1'b1), .PEND_MAX(3), .PEND_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_issue(s_issue), .flag_we(flag_we),
    .nzcv_in(nzcv_in), .msr_we(msr_we), .msr_nzcv(msr_nzcv),
    .cond_req(req1), .cond(cond), .cond_ack(ack1), .cond_pass(pass1),
    .stall(stall1), .nzcv_q(nzcv1), .cf(cf1), .vf(vf1), .pend_err(perr1),
    .state_dbg(st1), .pend_dbg(pend1)
  );

  nzcv_cond_unit #(.BYPASS(1'b0), .PEND_MAX(3), .PEND_W(2)) u_dut_b0 (
    .clk(clk), .rst_n(rst_n), .s_issue(s_issue), .flag_we(flag_we),
    .nzcv_in(nzcv_in), .msr_we(msr_we), .msr_nzcv(msr_nzcv),
    .cond_req(req0), .cond(cond), .cond_ack(ack0), .cond_pass(pass0),
    .stall(stall0), .nzcv_q(nzcv0), .cf(cf0), .vf(vf0), .pend_err(perr0),
    .state_dbg(st0), .pend_dbg(pend0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request on both instances, expect an ack after one edge, then release the
  // request and confirm that ack drops while the result holds.
  task automatic eval_both(input logic [3:0] c, input logic exp_pass, input string tag);
    cond = c;
    req1 = 1'b1;
    req0 = 1'b1;
    tick();
    chk({tag, "_ack"}, 8'(ack1), 8'(1'b1));
    chk({tag, "_pass"}, 8'(pass1), 8'(exp_pass));
    chk({tag, "_ack_b0"}, 8'(ack0), 8'(1'b1));
    chk({tag, "_pass_b0"}, 8'(pass0), 8'(exp_pass));
    req1 = 1'b0;
    req0 = 1'b0;
    tick();
    chk({tag, "_ackdrop"}, 8'(ack1), 8'(1'b0));
    chk({tag, "_passhold"}, 8'(pass1), 8'(exp_pass));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_nzcv"}, 8'(nzcv1), 8'h00);
    chk({tag, "_cf"}, 8'(cf1), 8'h00);
    chk({tag, "_vf"}, 8'(vf1), 8'h00);
    chk({tag, "_ack"}, 8'(ack1), 8'h00);
    chk({tag, "_pass"}, 8'(pass1), 8'h00);
    chk({tag, "_stall"}, 8'(stall1), 8'h00);
    chk({tag, "_perr"}, 8'(perr1), 8'h00);
    chk({tag, "_pend"}, 8'(pend1), 8'h00);
    chk({tag, "_state"}, 8'(st1), 8'h00);
  endtask

  logic [15:0] sweep_tab;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    s_issue  = 1'b0;
    flag_we  = 1'b0;
    nzcv_in  = 4'b0000;
    msr_we   = 1'b0;
    msr_nzcv = 4'b0000;
    req1     = 1'b0;
    req0     = 1'b0;
    cond     = 4'b0000;

    // reset state, before any clock edge
    #3;
    chk_all_zero("rst");
    tick();
    tick();
    rst_n = 1'b1;

    // EQ on zero flags: ack next cycle, fails
    eval_both(4'b0000, 1'b0, "eq_zero");

    // capture Z via flag_we, then EQ passes
    flag_we = 1'b1;
    nzcv_in = 4'b0100;
    tick();
    flag_we = 1'b0;
    chk("fw_nzcv", 8'(nzcv1), 8'h04);
    chk("fw_cf", 8'(cf1), 8'h00);
    chk("fw_vf", 8'(vf1), 8'h00);
    chk("fw_pend_floor", 8'(pend1), 8'h00);
    chk("fw_perr", 8'(perr1), 8'h00);
    eval_both(4'b0000, 1'b1, "eq_z");

    // MSR write N=1 V=1, then sweep all sixteen conditions
    msr_we   = 1'b1;
    msr_nzcv = 4'b1001;
    tick();
    msr_we = 1'b0;
    chk("msr_nzcv", 8'(nzcv1), 8'h09);
    chk("msr_cf", 8'(cf1), 8'h00);
    chk("msr_vf", 8'(vf1), 8'h01);
    chk("msr_pend", 8'(pend1), 8'h00);
    // bit i = expected result of condition i on N=1 Z=0 C=0 V=1
    sweep_tab = 16'h565A;
    for (int i = 0; i < 16; i++) begin
      eval_both(4'(i), sweep_tab[i], $sformatf("sweep%0d", i));
    end

    // pending flags stall a request; resolution timing per variant
    s_issue = 1'b1;
    tick();
    s_issue = 1'b0;
    chk("iss_pend", 8'(pend1), 8'h01);
    cond = 4'b0000;
    req1 = 1'b1;
    req0 = 1'b1;
    tick();
    chk("stl_stall", 8'(stall1), 8'h01);
    chk("stl_stall_b0", 8'(stall0), 8'h01);
    chk("stl_ack", 8'(ack1), 8'h00);
    tick();
    tick();
    chk("stl_hold", 8'(stall1), 8'h01);
    chk("stl_hold_ack", 8'(ack1), 8'h00);
    flag_we = 1'b1;
    nzcv_in = 4'b0100;
    tick();
    flag_we = 1'b0;
    chk("byp_ack", 8'(ack1), 8'h01);
    chk("byp_pass", 8'(pass1), 8'h01);
    chk("byp_stall", 8'(stall1), 8'h00);
    chk("nobyp_ack_early", 8'(ack0), 8'h00);
    chk("nobyp_stall", 8'(stall0), 8'h01);
    chk("stl_pend", 8'(pend1), 8'h00);
    req1 = 1'b0;
    tick();
    chk("byp_ackdrop", 8'(ack1), 8'h00);
    chk("nobyp_ack", 8'(ack0), 8'h01);
    chk("nobyp_pass", 8'(pass0), 8'h01);
    req0 = 1'b0;
    tick();
    chk("nobyp_ackdrop", 8'(ack0), 8'h00);

    // saturation: four issues, counter holds at 3 and error sticks
    s_issue = 1'b1;
    tick();
    tick();
    tick();
    chk("sat_pend3", 8'(pend1), 8'h03);
    chk("sat_perr_pre", 8'(perr1), 8'h00);
    tick();
    s_issue = 1'b0;
    chk("sat_pend_hold", 8'(pend1), 8'h03);
    chk("sat_perr", 8'(perr1), 8'h01);
    flag_we = 1'b1;
    nzcv_in = 4'b0110;
    tick();
    chk("drain_pend2", 8'(pend1), 8'h02);
    tick();
    chk("drain_pend1", 8'(pend1), 8'h01);
    tick();
    flag_we = 1'b0;
    chk("drain_pend0", 8'(pend1), 8'h00);
    chk("drain_pend0_b0", 8'(pend0), 8'h00);
    chk("drain_cf", 8'(cf1), 8'h01);
    eval_both(4'b0000, 1'b1, "post_drain");
    chk("perr_sticky", 8'(perr1), 8'h01);

    // flag_we beats msr_we
    flag_we  = 1'b1;
    nzcv_in  = 4'b0010;
    msr_we   = 1'b1;
    msr_nzcv = 4'b1100;
    tick();
    flag_we = 1'b0;
    msr_we  = 1'b0;
    chk("prio_nzcv", 8'(nzcv1), 8'h02);
    chk("prio_cf", 8'(cf1), 8'h01);
    chk("prio_vf", 8'(vf1), 8'h00);

    // issue and retire together leave the count unchanged
    s_issue = 1'b1;
    tick();
    chk("both_pre", 8'(pend1), 8'h01);
    flag_we = 1'b1;
    nzcv_in = 4'b0010;
    tick();
    s_issue = 1'b0;
    flag_we = 1'b0;
    chk("both_pend", 8'(pend1), 8'h01);

    // async reset while stalled
    cond = 4'b1110;
    req1 = 1'b1;
    req0 = 1'b1;
    tick();
    chk("rst2_stall_pre", 8'(stall1), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst2");
    req1 = 1'b0;
    req0 = 1'b0;
    tick();
    rst_n = 1'b1;
    eval_both(4'b1110, 1'b1, "post_rst_al");
    eval_both(4'b1111, 1'b0, "post_rst_nv");
    eval_both(4'b0011, 1'b1, "post_rst_cc");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
